// File: rtl/mips_core_pkg.sv
// Shared core types: AXI field widths, arbiter FSM states and instruction-side port indices.
package mips_core_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_ID_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_SB = 1'b1;

endpackage

// File: rtl/axi_read_address.sv
// AXI read-address (AR) channel bundle.
interface axi_read_address;
    import mips_core_pkg::*;

    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic [AXI_ID_W-1:0]   arid;

    modport master (output arvalid, output araddr, output arlen, output arid, input arready);
    modport slave  (input arvalid, input araddr, input arlen, input arid, output arready);
endinterface

// File: rtl/axi_read_data.sv
// AXI read-data (R) channel bundle.
interface axi_read_data;
    import mips_core_pkg::*;

    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;

    modport master (input rvalid, input rdata, output rready);
    modport slave  (output rvalid, output rdata, input rready);
endinterface

// File: rtl/arb_priority_select.sv
// Winner selection for the instruction-side read arbiter: port 0 has fixed priority,
// port 1 is forced through after STARVE_LIMIT consecutive contested losses.
module arb_priority_select
    import mips_core_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic req_ic,
    input  logic req_sb,
    output logic grant_valid,
    output logic grant_port
);

    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 starved;

    assign starved = (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));

    always_comb begin
        grant_valid = arb_en && (req_ic || req_sb);
        grant_port  = PORT_IC;
        if (req_sb && (!req_ic || starved)) begin
            grant_port = PORT_SB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_valid) begin
            if (grant_port == PORT_SB) begin
                starve_cnt <= '0;
            end else if (req_sb && !starved) begin
                starve_cnt <= starve_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/i_fetch_read_arbiter.sv
// Merges the i-cache refill (port 0) and stream-buffer prefetch (port 1) AXI read masters
// onto one memory read channel, one burst outstanding, grant locked until the last beat.
module i_fetch_read_arbiter
    import mips_core_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_read_address.slave  ic_read_address,
    axi_read_data.slave     ic_read_data,
    axi_read_address.slave  sb_read_address,
    axi_read_data.slave     sb_read_data,
    axi_read_address.master mem_read_address,
    axi_read_data.master    mem_read_data
);

    arb_state_t            state;
    logic                  owner;
    logic [AXI_ADDR_W-1:0] addr;
    logic [CNT_WIDTH-1:0]  len;
    logic [AXI_ID_W-1:0]   id;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    logic grant_valid;
    logic grant_port;
    logic in_addr;
    logic in_data;
    logic beat_fire;
    logic last_beat;

    arb_priority_select #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_select (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en      (state == ARB_IDLE),
        .req_ic      (ic_read_address.arvalid),
        .req_sb      (sb_read_address.arvalid),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign in_addr = (state == ARB_ADDR);
    assign in_data = (state == ARB_DATA);

    assign mem_read_address.arvalid = in_addr;
    assign mem_read_address.araddr  = addr;
    assign mem_read_address.arlen   = AXI_LEN_W'(len);
    assign mem_read_address.arid    = id;

    assign ic_read_address.arready = in_addr && (owner == PORT_IC) && mem_read_address.arready;
    assign sb_read_address.arready = in_addr && (owner == PORT_SB) && mem_read_address.arready;

    // Data beats outside DATA are protocol violations from memory and are swallowed here.
    assign ic_read_data.rvalid = in_data && (owner == PORT_IC) && mem_read_data.rvalid;
    assign sb_read_data.rvalid = in_data && (owner == PORT_SB) && mem_read_data.rvalid;
    assign ic_read_data.rdata  = mem_read_data.rdata;
    assign sb_read_data.rdata  = mem_read_data.rdata;
    assign mem_read_data.rready = in_data &&
        ((owner == PORT_SB) ? sb_read_data.rready : ic_read_data.rready);

    assign beat_fire = in_data && mem_read_data.rvalid && mem_read_data.rready;
    assign last_beat = (len == '0) || (beat_cnt == len - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= PORT_IC;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_port;
                        state <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (mem_read_address.arready) begin
                        beat_cnt <= '0;
                        state    <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        if (last_beat) begin
                            state <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // NOTE: the request fields are only read in ADDR/DATA after being loaded at grant, so they carry no reset.
    always_ff @(posedge clk) begin
        if (grant_valid) begin
            if (grant_port == PORT_SB) begin
                addr <= sb_read_address.araddr;
                len  <= CNT_WIDTH'(sb_read_address.arlen);
                id   <= sb_read_address.arid;
            end else begin
                addr <= ic_read_address.araddr;
                len  <= CNT_WIDTH'(ic_read_address.arlen);
                id   <= ic_read_address.arid;
            end
        end
    end

endmodule

// File: tb/tb_i_fetch_read_arbiter.sv
// Randomised bench for i_fetch_read_arbiter: transaction-level reference model plus
// upstream master and memory models with an end-to-end data scoreboard.
module tb_i_fetch_read_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_req;

    always #5 clk = ~clk;

    axi_read_address ic_ar ();
    axi_read_data    ic_rd ();
    axi_read_address sb_ar ();
    axi_read_data    sb_rd ();
    axi_read_address mem_ar ();
    axi_read_data    mem_rd ();

    i_fetch_read_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ic_read_address  (ic_ar),
        .ic_read_data     (ic_rd),
        .sb_read_address  (sb_ar),
        .sb_read_data     (sb_rd),
        .mem_read_address (mem_ar),
        .mem_read_data    (mem_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    req_t dq_ic[$];
    req_t dq_sb[$];

    // upstream masters: presented request, outstanding burst, bookkeeping
    logic        req_v [2];
    logic [31:0] req_a [2];
    logic [7:0]  req_l [2];
    logic        out_v [2];
    logic [31:0] out_a [2];
    int          out_total [2];
    int          out_beat [2];
    int          issued [2];
    int          done [2];
    logic        up_rready [2];

    // memory slave model
    logic        mem_busy;
    logic [31:0] mem_a;
    int          mem_total;
    int          mem_beat;

    int p_req [2];
    int p_arready, p_rvalid, p_rready, p_spur;

    // reference model: the burst currently holding the memory channel
    logic        m_valid, m_acc, m_port;
    logic [31:0] m_a;
    logic [7:0]  m_l;
    int          m_beats;
    int          starve;

    function automatic int beats_of(logic [7:0] l);
        return (l == 8'd0) ? 1 : int'(l);
    endfunction

    function automatic logic [31:0] beat_data(logic [31:0] a, int b);
        return {a[15:0], 16'(b)} ^ 32'h5A5A_3C3C;
    endfunction

    function automatic bit chance(int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_bench();
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; out_v[p] = 1'b0; out_beat[p] = 0; out_total[p] = 0;
            issued[p] = 0;   done[p] = 0;
        end
        mem_busy = 1'b0; mem_beat = 0; mem_total = 0;
        m_valid = 1'b0;  m_acc = 1'b0; m_beats = 0; starve = 0;
    endtask

    task automatic drive();
        req_t r;
        bit   got;
        rst_n = rst_req;
        for (int p = 0; p < 2; p++) begin
            got = 1'b0;
            if (rst_n && !req_v[p] && !out_v[p]) begin
                if (p == 0 && dq_ic.size() > 0) begin
                    r = dq_ic.pop_front(); got = 1'b1;
                end else if (p == 1 && dq_sb.size() > 0) begin
                    r = dq_sb.pop_front(); got = 1'b1;
                end else if (chance(p_req[p])) begin
                    r.a = $urandom & 32'hFFFF_FFF0;
                    r.l = 8'($urandom_range(6, 0));
                    got = 1'b1;
                end
            end
            if (got) begin
                req_a[p] = r.a; req_l[p] = r.l; req_v[p] = 1'b1; issued[p]++;
            end
            up_rready[p] = chance(p_rready);
        end
        ic_ar.arvalid = req_v[0]; ic_ar.araddr = req_a[0]; ic_ar.arlen = req_l[0]; ic_ar.arid = 4'd1;
        sb_ar.arvalid = req_v[1]; sb_ar.araddr = req_a[1]; sb_ar.arlen = req_l[1]; sb_ar.arid = 4'd2;
        ic_rd.rready = up_rready[0];
        sb_rd.rready = up_rready[1];
        mem_ar.arready = chance(p_arready);
        if (mem_busy) begin
            mem_rd.rvalid = chance(p_rvalid);
            mem_rd.rdata  = beat_data(mem_a, mem_beat);
        end else begin
            mem_rd.rvalid = rst_n && chance(p_spur);
            mem_rd.rdata  = $urandom;
        end
    endtask

    task automatic sample();
        logic e_arv, e_rr, owner_rr;
        logic ar_rdy [2];
        logic r_fire [2];
        owner_rr = m_port ? up_rready[1] : up_rready[0];
        e_arv    = m_valid && !m_acc;
        e_rr     = m_valid && m_acc && owner_rr;

        check("mem_arvalid", mem_ar.arvalid, e_arv);
        if (e_arv) begin
            check("mem_araddr", mem_ar.araddr, m_a);
            check("mem_arlen", mem_ar.arlen, m_l);
            check("mem_arid", mem_ar.arid, m_port ? 4'd2 : 4'd1);
        end
        check("ic_arready", ic_ar.arready, e_arv && !m_port && mem_ar.arready);
        check("sb_arready", sb_ar.arready, e_arv && m_port && mem_ar.arready);
        check("ic_rvalid", ic_rd.rvalid, m_valid && m_acc && !m_port && mem_rd.rvalid);
        check("sb_rvalid", sb_rd.rvalid, m_valid && m_acc && m_port && mem_rd.rvalid);
        check("mem_rready", mem_rd.rready, e_rr);
        if (mem_rd.rvalid) begin
            check("ic_rdata_bcast", ic_rd.rdata, mem_rd.rdata);
            check("sb_rdata_bcast", sb_rd.rdata, mem_rd.rdata);
        end

        if (!rst_n) begin
            reset_bench();
            return;
        end

        // model advance for the coming edge, from the inputs the bench is presenting
        if (!m_valid) begin
            if (req_v[0] || req_v[1]) begin
                m_port = req_v[1] && (!req_v[0] || starve == STARVE_LIMIT);
                if (req_v[1])
                    starve = m_port ? 0 : ((starve < STARVE_LIMIT) ? starve + 1 : starve);
                m_valid = 1'b1; m_acc = 1'b0;
                m_a = req_a[m_port]; m_l = req_l[m_port];
            end
        end else if (!m_acc) begin
            if (mem_ar.arready) begin
                m_acc = 1'b1; m_beats = 0;
            end
        end else if (mem_rd.rvalid && owner_rr) begin
            m_beats++;
            if (m_beats == beats_of(m_l)) m_valid = 1'b0;
        end

        // upstream masters react to what the DUT actually presented
        ar_rdy[0] = ic_ar.arready; ar_rdy[1] = sb_ar.arready;
        r_fire[0] = ic_rd.rvalid && ic_rd.rready;
        r_fire[1] = sb_rd.rvalid && sb_rd.rready;
        for (int p = 0; p < 2; p++) begin
            if (req_v[p] && ar_rdy[p]) begin
                out_v[p] = 1'b1; out_a[p] = req_a[p];
                out_total[p] = beats_of(req_l[p]); out_beat[p] = 0; req_v[p] = 1'b0;
            end else if (r_fire[p] === 1'b1) begin
                check(p ? "sb_beat_expected" : "ic_beat_expected", out_v[p], 1'b1);
                if (out_v[p]) begin
                    check(p ? "sb_beat_data" : "ic_beat_data",
                          p ? sb_rd.rdata : ic_rd.rdata, beat_data(out_a[p], out_beat[p]));
                    out_beat[p]++;
                    if (out_beat[p] == out_total[p]) begin
                        out_v[p] = 1'b0; done[p]++;
                    end
                end
            end
        end

        if (mem_ar.arvalid && mem_ar.arready && !mem_busy) begin
            mem_busy = 1'b1; mem_a = mem_ar.araddr;
            mem_total = beats_of(mem_ar.arlen); mem_beat = 0;
        end else if (mem_busy && mem_rd.rvalid && mem_rd.rready) begin
            mem_beat++;
            if (mem_beat == mem_total) mem_busy = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        sample();
    endtask

    task automatic set_knobs(int pic, int psb, int parr, int prv, int prr, int psp);
        p_req[0] = pic; p_req[1] = psb;
        p_arready = parr; p_rvalid = prv; p_rready = prr; p_spur = psp;
    endtask

    initial begin
        reset_bench();
        set_knobs(0, 0, 100, 100, 100, 0);
        rst_req = 1'b0;
        drive();
        repeat (3) cycle();
        rst_req = 1'b1;

        // single i-cache miss, 4 beats
        dq_ic.push_back('{a: 32'h1000, l: 8'd4});
        repeat (12) cycle();

        // contested grant in the same cycle
        dq_ic.push_back('{a: 32'h2000, l: 8'd2});
        dq_sb.push_back('{a: 32'h3010, l: 8'd3});
        repeat (20) cycle();

        // anti-starvation: sb waits behind back-to-back i-cache misses
        for (int i = 0; i < 5; i++) dq_ic.push_back('{a: 32'h8000 + 32'(i * 16), l: 8'd1});
        dq_sb.push_back('{a: 32'h9000, l: 8'd2});
        repeat (60) cycle();

        // AR/R backpressure and stray memory beats
        set_knobs(0, 0, 25, 70, 50, 30);
        dq_ic.push_back('{a: 32'h6000, l: 8'd4});
        repeat (60) cycle();

        // reset after the first beat of a 4-beat burst
        set_knobs(0, 0, 100, 100, 100, 0);
        repeat (10) cycle();
        dq_ic.push_back('{a: 32'h4000, l: 8'd4});
        for (int i = 0; i < 40 && !(out_v[0] && out_beat[0] >= 1); i++) cycle();
        check("reset_setup_beat1", out_beat[0], 1);
        rst_req = 1'b0;
        cycle();
        rst_req = 1'b1;
        dq_sb.push_back('{a: 32'h7000, l: 8'd3});
        repeat (15) cycle();

        // ARLEN=0 is a single beat
        dq_sb.push_back('{a: 32'h5000, l: 8'd0});
        repeat (8) cycle();

        for (int k = 0; k < 8; k++) begin
            set_knobs($urandom_range(100, 10), $urandom_range(100, 10), $urandom_range(100, 20),
                      $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(30, 0));
            if (k == 5) begin
                rst_req = 1'b0;
                cycle();
                rst_req = 1'b1;
            end
            repeat (400) cycle();
        end

        // drain: every request issued since the last reset must complete
        set_knobs(0, 0, 100, 100, 100, 0);
        repeat (40) cycle();
        check("ic_all_served", done[0], issued[0]);
        check("sb_all_served", done[1], issued[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
